// File: rtl/wb_pwm_pkg.sv
// Shared register map, control-bit positions and counter direction type
// for the Wishbone PWM controller.
package wb_pwm_pkg;

  localparam int ADDR_CTRL   = 0;
  localparam int ADDR_PERIOD = 1;
  localparam int ADDR_PRESC  = 2;
  localparam int ADDR_STATUS = 3;
  localparam int ADDR_DUTY0  = 4;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_INV    = 1;
  localparam int CTRL_CENTER = 2;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Number of word addresses decoded for a given channel count.
  function automatic int reg_count(input int chans);
    return ADDR_DUTY0 + chans;
  endfunction

endpackage

// File: rtl/pwm_chan_cmp.sv
// One PWM channel: active duty register, compare against the shared
// counter, optional inversion and the output register.
module pwm_chan_cmp
  import wb_pwm_pkg::*;
#(
  parameter int PWM_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [PWM_BITS-1:0] duty_ld,
  input  logic [PWM_BITS-1:0] cnt,
  input  logic                en,
  input  logic                inv,
  output logic                pwm
);

  logic [PWM_BITS-1:0] duty_act;
  logic                raw;

  // Active duty follows the shadow only when the counter allows a reload.
  always_ff @(posedge clk) begin
    if (!rst_n)    duty_act <= '0;
    else if (load) duty_act <= duty_ld;
  end

  // Raw compare; gated off while disabled so the pin rests at INV.
  always_comb begin
    raw = en && (cnt < duty_act);
  end

  // Registered output, one clock behind the counter.
  always_ff @(posedge clk) begin
    if (!rst_n) pwm <= 1'b0;
    else        pwm <= raw ^ inv;
  end

endmodule

// File: rtl/wb_pwm_ctrl.sv
// Wishbone-controlled multi-channel PWM: register file, prescaler,
// edge/center counter and per-channel comparators.
//
// dir state | meaning
// DIR_UP    | counter incrementing (edge mode always stays here)
// DIR_DOWN  | center mode, counting back down towards 0
module wb_pwm_ctrl
  import wb_pwm_pkg::*;
#(
  parameter int WB_ADDR_BITS = 32,
  parameter int PWM_BITS     = 16,
  parameter int PWM_CHANS    = 4,
  parameter int PRESC_BITS   = 8
) (
  input  logic                    i_wb_clk,
  input  logic                    i_wb_rst_n,
  input  logic                    i_wb_stb,
  input  logic                    i_wb_we,
  input  logic [WB_ADDR_BITS-1:0] i_wb_addr,
  input  logic [31:0]             i_wb_data,
  output logic [31:0]             o_wb_data,
  output logic                    o_wb_stall,
  output logic                    o_wb_ack,
  output logic [PWM_CHANS-1:0]    o_pwm_chan,
  output logic                    o_pwm_period
);

  logic                  en, inv, center_cfg, center_nxt, center_act;
  logic [PWM_BITS-1:0]   period_sh, period_sh_nxt, period_act, cnt;
  logic [PWM_BITS-1:0]   duty_sh     [PWM_CHANS];
  logic [PWM_BITS-1:0]   duty_sh_nxt [PWM_CHANS];
  logic [PRESC_BITS-1:0] presc, presc_cnt;
  dir_t                  dir;
  logic                  wr, ctrl_wr, presc_wr, tick, boundary, load;
  logic [31:0]           rd_data;
  logic                  unused_wdata;

  assign o_wb_stall   = 1'b0;
  assign unused_wdata = ^i_wb_data;

  // Write decode; shadow next-values feed both the shadows and a
  // coincident active reload so a write on a boundary tick lands at once.
  always_comb begin
    wr            = i_wb_stb && i_wb_we;
    ctrl_wr       = wr && (i_wb_addr == WB_ADDR_BITS'(ADDR_CTRL));
    presc_wr      = wr && (i_wb_addr == WB_ADDR_BITS'(ADDR_PRESC));
    center_nxt    = ctrl_wr ? i_wb_data[CTRL_CENTER] : center_cfg;
    period_sh_nxt = period_sh;
    duty_sh_nxt   = duty_sh;
    if (wr && (i_wb_addr == WB_ADDR_BITS'(ADDR_PERIOD)))
      period_sh_nxt = i_wb_data[PWM_BITS-1:0];
    for (int n = 0; n < PWM_CHANS; n++) begin
      if (wr && (i_wb_addr == WB_ADDR_BITS'(ADDR_DUTY0 + n)))
        duty_sh_nxt[n] = i_wb_data[PWM_BITS-1:0];
    end
  end

  // Read mux; unmapped addresses return 0.
  always_comb begin
    rd_data = '0;
    if (i_wb_addr == WB_ADDR_BITS'(ADDR_CTRL)) begin
      rd_data[CTRL_EN]     = en;
      rd_data[CTRL_INV]    = inv;
      rd_data[CTRL_CENTER] = center_cfg;
    end
    if (i_wb_addr == WB_ADDR_BITS'(ADDR_PERIOD)) rd_data[PWM_BITS-1:0]   = period_sh;
    if (i_wb_addr == WB_ADDR_BITS'(ADDR_PRESC))  rd_data[PRESC_BITS-1:0] = presc;
    if (i_wb_addr == WB_ADDR_BITS'(ADDR_STATUS)) rd_data[PWM_BITS-1:0]   = cnt;
    for (int n = 0; n < PWM_CHANS; n++) begin
      if (i_wb_addr == WB_ADDR_BITS'(ADDR_DUTY0 + n)) rd_data[PWM_BITS-1:0] = duty_sh[n];
    end
  end

  // Tick and period-boundary detection.
  always_comb begin
    tick     = en && (presc_cnt >= presc);
    boundary = 1'b0;
    if (tick) begin
      if (period_act == '0)  boundary = 1'b1;
      else if (!center_act)  boundary = (cnt >= period_act);
      else                   boundary = (dir == DIR_DOWN) && (cnt == '0);
    end
    load = !en || boundary;
  end

  // Bus-visible configuration registers and shadows.
  always_ff @(posedge i_wb_clk) begin
    if (!i_wb_rst_n) begin
      en         <= 1'b0;
      inv        <= 1'b0;
      center_cfg <= 1'b0;
      presc      <= '0;
      period_sh  <= '0;
      for (int n = 0; n < PWM_CHANS; n++) duty_sh[n] <= '0;
    end else begin
      if (ctrl_wr) begin
        en         <= i_wb_data[CTRL_EN];
        inv        <= i_wb_data[CTRL_INV];
        center_cfg <= i_wb_data[CTRL_CENTER];
      end
      if (presc_wr) presc <= i_wb_data[PRESC_BITS-1:0];
      period_sh <= period_sh_nxt;
      duty_sh   <= duty_sh_nxt;
    end
  end

  // Active period and counting mode reload at a boundary or while idle.
  always_ff @(posedge i_wb_clk) begin
    if (!i_wb_rst_n) begin
      period_act <= '0;
      center_act <= 1'b0;
    end else if (load) begin
      period_act <= period_sh_nxt;
      center_act <= center_nxt;
    end
  end

  // Prescaler and up/down counter; held at 0/up while disabled.
  always_ff @(posedge i_wb_clk) begin
    if (!i_wb_rst_n || !en) begin
      cnt       <= '0;
      presc_cnt <= '0;
      dir       <= DIR_UP;
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + PRESC_BITS'(1);
      if (tick) begin
        if (boundary) begin
          // Center mode shares the 0 with the down slope, so it resumes at 1.
          dir <= DIR_UP;
          cnt <= (center_act && center_nxt && (period_sh_nxt != '0)) ? PWM_BITS'(1) : '0;
        end else if (!center_act) begin
          cnt <= cnt + PWM_BITS'(1);
        end else if (dir == DIR_UP) begin
          if (cnt >= period_act) begin
            dir <= DIR_DOWN;
            cnt <= cnt - PWM_BITS'(1);
          end else begin
            cnt <= cnt + PWM_BITS'(1);
          end
        end else begin
          cnt <= cnt - PWM_BITS'(1);
        end
      end
    end
  end

  // Pipelined bus response and period pulse.
  always_ff @(posedge i_wb_clk) begin
    if (!i_wb_rst_n) begin
      o_wb_ack     <= 1'b0;
      o_wb_data    <= '0;
      o_pwm_period <= 1'b0;
    end else begin
      o_wb_ack     <= i_wb_stb;
      o_wb_data    <= (i_wb_stb && !i_wb_we) ? rd_data : '0;
      o_pwm_period <= boundary;
    end
  end

  for (genvar g = 0; g < PWM_CHANS; g++) begin : g_chan
    pwm_chan_cmp #(.PWM_BITS(PWM_BITS)) u_cmp (
      .clk     (i_wb_clk),
      .rst_n   (i_wb_rst_n),
      .load    (load),
      .duty_ld (duty_sh_nxt[g]),
      .cnt     (cnt),
      .en      (en),
      .inv     (inv),
      .pwm     (o_pwm_chan[g])
    );
  end

endmodule

// File: tb/tb_wb_pwm_ctrl.sv
// Directed testbench for wb_pwm_ctrl with hand-computed expectations.
module tb_wb_pwm_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, stb, we;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        stall, ack, pulse;
  logic [3:0]  chan;
  logic [31:0] c0, c1, pp;

  int n_asserts = 0;
  int n_fails   = 0;

  wb_pwm_ctrl #(
    .WB_ADDR_BITS(32), .PWM_BITS(16), .PWM_CHANS(4), .PRESC_BITS(8)
  ) dut (
    .i_wb_clk     (clk),
    .i_wb_rst_n   (rst_n),
    .i_wb_stb     (stb),
    .i_wb_we      (we),
    .i_wb_addr    (addr),
    .i_wb_data    (wdata),
    .o_wb_data    (rdata),
    .o_wb_stall   (stall),
    .o_wb_ack     (ack),
    .o_pwm_chan   (chan),
    .o_pwm_period (pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    stb = 1'b1; we = 1'b1; addr = a; wdata = d;
    step(1);
    stb = 1'b0; we = 1'b0;
    chk("wr_ack", {31'b0, ack}, 32'd1);
  endtask

  task automatic wb_read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    stb = 1'b1; we = 1'b0; addr = a;
    step(1);
    stb = 1'b0;
    chk({tag, "_ack"}, {31'b0, ack}, 32'd1);
    chk(tag, rdata, exp);
  endtask

  task automatic wait_pulse(input string tag, input int budget);
    int k = 0;
    while (!pulse && k < budget) begin
      step(1);
      k++;
    end
    chk({tag, "_pulse_seen"}, {31'b0, pulse}, 32'd1);
  endtask

  // Samples the current cycle and n-1 following cycles.
  task automatic capture(input int n, output logic [31:0] o0, output logic [31:0] o1,
                         output logic [31:0] op);
    o0 = '0; o1 = '0; op = '0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) step(1);
      o0[i] = chan[0];
      o1[i] = chan[1];
      op[i] = pulse;
    end
  endtask

  initial begin
    rst_n = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0;

    // Reset state
    step(3);
    chk("rst_chan", {28'b0, chan}, 32'h0);
    chk("rst_period", {31'b0, pulse}, 32'h0);
    chk("rst_ack", {31'b0, ack}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("stall", {31'b0, stall}, 32'h0);
    rst_n = 1'b1;
    step(1);
    wb_read_chk("rst_ctrl", 32'd0, 32'h0);
    wb_read_chk("rst_periodreg", 32'd1, 32'h0);
    wb_read_chk("rst_duty0", 32'd4, 32'h0);

    // Edge mode: PERIOD=9, DUTY0=3 -> 3 high / 7 low, pulse every 10
    wb_write(32'd1, 32'd9);
    wb_write(32'd2, 32'd0);
    wb_write(32'd4, 32'd3);
    wb_write(32'd0, 32'd1);
    wb_read_chk("period_rb", 32'd1, 32'd9);
    wait_pulse("edge", 40);
    capture(20, c0, c1, pp);
    chk("edge_chan0", c0, 32'h0000380E);
    chk("edge_pulse", pp, 32'h00000401);

    // STATUS mid-period
    wait_pulse("status", 40);
    step(3);
    wb_read_chk("status_cnt3", 32'd3, 32'd3);

    // DUTY0 3->7 mid-period: current keeps 3, next shows 7
    wait_pulse("duty_chg", 40);
    wb_write(32'd4, 32'd7);
    capture(20, c0, c1, pp);
    chk("duty_chg_chan0", c0, 32'h0001FC07);
    chk("duty_chg_pulse", pp, 32'h00080200);

    // Disable: outputs rest at INV=0, no pulses, counter 0
    wb_write(32'd0, 32'd0);
    step(2);
    chk("dis_chan", {28'b0, chan}, 32'h0);
    chk("dis_pulse", {31'b0, pulse}, 32'h0);
    wb_read_chk("dis_status", 32'd3, 32'd0);

    // Center mode: PERIOD=4, DUTY0=2 -> 1,1,0,0,0,0,0,1 every 8
    wb_write(32'd1, 32'd4);
    wb_write(32'd4, 32'd2);
    wb_write(32'd0, 32'd5);
    wb_read_chk("ctrl_rb", 32'd0, 32'd5);
    wait_pulse("center", 40);
    capture(16, c0, c1, pp);
    chk("center_chan0", c0, 32'h00008383);
    chk("center_pulse", pp, 32'h00000101);

    // Idle with INV=1: all outputs high
    wb_write(32'd0, 32'd2);
    step(1);
    chk("inv_idle_chan", {28'b0, chan}, 32'hF);

    // PRESC=2, PERIOD=3, DUTY0=0, DUTY1=5, INV=1 -> 12-clock period
    wb_write(32'd2, 32'd2);
    wb_write(32'd1, 32'd3);
    wb_write(32'd4, 32'd0);
    wb_write(32'd5, 32'd5);
    wb_write(32'd0, 32'd3);
    wait_pulse("presc", 60);
    capture(25, c0, c1, pp);
    chk("presc_chan0", c0, 32'h01FFFFFF);
    chk("presc_chan1", c1, 32'h00000000);
    chk("presc_pulse", pp, 32'h01001001);

    // PERIOD=0: pulse on every clock, counter stays 0
    wb_write(32'd2, 32'd0);
    wb_write(32'd1, 32'd0);
    step(15);
    capture(4, c0, c1, pp);
    chk("p0_pulse", pp, 32'h0000000F);
    wb_read_chk("p0_status", 32'd3, 32'd0);

    // Back-to-back strobes
    stb = 1'b1; we = 1'b1; addr = 32'd6; wdata = 32'h55;
    step(1);
    chk("b2b_ack_wr", {31'b0, ack}, 32'd1);
    we = 1'b0; addr = 32'd6;
    step(1);
    chk("b2b_ack_rd1", {31'b0, ack}, 32'd1);
    chk("b2b_rd_duty2", rdata, 32'h55);
    addr = 32'h40;
    step(1);
    chk("b2b_ack_rd2", {31'b0, ack}, 32'd1);
    chk("b2b_rd_unmapped", rdata, 32'h0);
    stb = 1'b0;
    step(1);
    chk("b2b_ack_idle", {31'b0, ack}, 32'd0);

    // Unmapped write is ignored (no aliasing onto CTRL)
    wb_write(32'h40, 32'hFFFF_FFFF);
    wb_read_chk("unmapped_wr_ctrl", 32'd0, 32'd3);

    // Reset pulse mid-period, overriding a concurrent CTRL write
    wb_write(32'd0, 32'd0);
    wb_write(32'd1, 32'd9);
    wb_write(32'd4, 32'd3);
    wb_write(32'd0, 32'd1);
    wait_pulse("pre_rst", 40);
    step(1);
    chk("pre_rst_chan0", {31'b0, chan[0]}, 32'd1);
    rst_n = 1'b0; stb = 1'b1; we = 1'b1; addr = 32'd0; wdata = 32'd7;
    step(1);
    rst_n = 1'b1; stb = 1'b0; we = 1'b0;
    chk("post_rst_chan", {28'b0, chan}, 32'h0);
    chk("post_rst_pulse", {31'b0, pulse}, 32'h0);
    chk("post_rst_ack", {31'b0, ack}, 32'h0);
    chk("post_rst_rdata", rdata, 32'h0);
    wb_read_chk("post_rst_status", 32'd3, 32'd0);
    wb_read_chk("post_rst_ctrl", 32'd0, 32'd0);
    wb_read_chk("post_rst_periodreg", 32'd1, 32'd0);
    step(5);
    chk("post_rst_chan_idle", {28'b0, chan}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
